ifetch_prefetch: RTL

// Instruction fetch stage directly upstream of the instruction RAM. Drives
// 8-byte-aligned read beats (HADDR/HWRITE/HTRANS) and captures 64-bit HRDATA.

---
 rtl/ifetch_prefetch.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage: issues 8-byte read beats, splits each beat into two
// 32-bit instructions and queues them in a small prefetch FIFO drained by decode.
module ifetch_prefetch #(
  parameter logic [63:0] RESET_PC   = 64'h1000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [63:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [63:0] HRDATA,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0] S_BOOT  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  logic [0:0]    state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   data_d [FIFO_DEPTH];
  logic [63:0]   pc_q   [FIFO_DEPTH];
  logic [63:0]   pc_d   [FIFO_DEPTH];

  logic [63:0]   aligned_s;
  logic [CW-1:0] need_s;
  logic [CW-1:0] space_s;
  logic          issue_s;
  logic          beat_done_s;
  logic          pop_s;
  logic [PW-1:0] wp_s;
  logic [CW-1:0] npush_s;
  logic          unused_s;

  // A pop in the same cycle is deliberately not credited as free space.
  assign aligned_s   = {fetch_pc_q[63:3], 3'b000};
  assign need_s      = fetch_pc_q[2] ? CW'(1) : CW'(2);
  assign space_s     = CW'(FIFO_DEPTH) - count_q;
  assign issue_s     = (state_q == S_FETCH) && (space_s >= need_s);
  assign beat_done_s = issue_s && HREADY;
  assign pop_s       = inst_valid && inst_ready;
  assign unused_s    = ^redirect_pc[1:0];

  assign HADDR      = aligned_s;
  assign HWRITE     = 1'b0;
  assign HTRANS     = issue_s ? HT_NONSEQ : HT_IDLE;
  assign inst_valid = (count_q != '0);
  assign inst_data  = data_q[rd_ptr_q];
  assign inst_pc    = pc_q[rd_ptr_q];

  // Next-state: redirect overrides beat capture and pop; otherwise push in address order.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    pc_d       = pc_q;
    wp_s       = wr_ptr_q;
    npush_s    = '0;
    if (redirect_valid) begin
      state_d    = S_FETCH;
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_FETCH;
        S_FETCH: state_d = S_FETCH;
        default: state_d = S_BOOT;
      endcase
      if (beat_done_s) begin
        if (!fetch_pc_q[2]) begin
          data_d[wp_s] = HRDATA[31:0];
          pc_d[wp_s]   = aligned_s;
          wp_s         = wp_s + PW'(1);
          npush_s      = CW'(1);
        end else begin
          npush_s      = '0;
        end
        data_d[wp_s] = HRDATA[63:32];
        pc_d[wp_s]   = aligned_s + 64'd4;
        wp_s         = wp_s + PW'(1);
        npush_s      = npush_s + CW'(1);
        fetch_pc_d   = aligned_s + 64'd8;
      end else begin
        fetch_pc_d   = fetch_pc_q;
      end
      wr_ptr_d = wp_s;
      rd_ptr_d = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + npush_s - CW'(pop_s);
    end
  end

  // State and FIFO storage; entries are cleared on reset so the head reads zero.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= 32'd0;
        pc_q[i]   <= 64'd0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

endmodule
